// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the cpu_sequencer control path: opcodes, ALU encodings,
// FSM state codes and instruction field positions.
package cpu_sequencer_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_ADD  = 6'b000000;
    localparam opcode_t OP_SUB  = 6'b000001;
    localparam opcode_t OP_JMP  = 6'b000010;
    localparam opcode_t OP_BEQ  = 6'b000011;
    localparam opcode_t OP_HALT = 6'b111111;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StFetch     = 3'd1;
    localparam logic [2:0] StDecode    = 3'd2;
    localparam logic [2:0] StExecute   = 3'd3;
    localparam logic [2:0] StWriteback = 3'd4;
    localparam logic [2:0] StHalt      = 3'd5;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned OFF_MSB = 25;
    localparam int unsigned OFF_LSB = 18;
    localparam int unsigned RD_MSB  = 17;
    localparam int unsigned RD_LSB  = 12;
    localparam int unsigned TGT_MSB = 15;
    localparam int unsigned TGT_LSB = 0;

endpackage

// File: rtl/cpu_sequencer_instr_classify.sv
// Combinational opcode classifier: instruction class flags and the ALU operation
// each class requests.
module cpu_sequencer_instr_classify
    import cpu_sequencer_pkg::*;
(
    input  opcode_t    opcode,
    output logic       is_alu,
    output logic       is_jmp,
    output logic       is_beq,
    output logic       is_halt,
    output logic       is_illegal,
    output logic [1:0] alu_sel
);

    always_comb begin
        is_alu     = 1'b0;
        is_jmp     = 1'b0;
        is_beq     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_sel    = ALU_NONE;
        case (opcode)
            OP_ADD: begin
                is_alu  = 1'b1;
                alu_sel = ALU_ADD;
            end
            OP_SUB: begin
                is_alu  = 1'b1;
                alu_sel = ALU_SUB;
            end
            OP_JMP:  is_jmp = 1'b1;
            // BEQ compares by subtraction; alu_zero reports equality
            OP_BEQ: begin
                is_beq  = 1'b1;
                alu_sel = ALU_SUB;
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC and instruction register, fetches over a
// req/ready handshake and steps each instruction through decode/execute/writeback.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic [1:0]          alu_op,
    input  logic                alu_zero,
    output logic                reg_write,
    output logic [5:0]          wb_addr,
    output logic [PC_W-1:0]     pc,
    output logic [2:0]          state,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    logic [2:0]          state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic                reg_write_q, reg_write_d;
    logic                imem_req_q, imem_req_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire;

    logic       is_alu, is_jmp, is_beq, is_halt, is_illegal;
    logic [1:0] alu_sel;
    logic [7:0] br_off;

    cpu_sequencer_instr_classify u_classify (
        .opcode     (instr_q[OPC_MSB:OPC_LSB]),
        .is_alu     (is_alu),
        .is_jmp     (is_jmp),
        .is_beq     (is_beq),
        .is_halt    (is_halt),
        .is_illegal (is_illegal),
        .alu_sel    (alu_sel)
    );

    assign br_off = instr_q[OFF_MSB:OFF_LSB];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_halt) begin
                    state_d   = StHalt;
                    illegal_d = 1'b0;
                end else if (is_illegal) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                if (is_alu) begin
                    state_d = StWriteback;
                end else begin
                    // pc already points past the branch, so the offset is relative to it
                    if (is_jmp) begin
                        pc_d = PC_W'(instr_q[TGT_MSB:TGT_LSB]);
                    end else if (is_beq && alu_zero) begin
                        pc_d = pc_q + {{(PC_W-8){br_off[7]}}, br_off};
                    end
                    retire = 1'b1;
                end
            end
            StWriteback: retire = 1'b1;
            StHalt:      state_d = StHalt;
            default:     state_d = StIdle;
        endcase
        if (retire) state_d = run ? StFetch : StIdle;
    end

    always_comb begin
        alu_op_d = ALU_NONE;
        if (state_d == StExecute) begin
            alu_op_d = alu_sel;
        end else if (state_d == StWriteback) begin
            alu_op_d = alu_op_q;
        end
        reg_write_d = (state_d == StWriteback);
        imem_req_d  = (state_d == StFetch);
        halted_d    = (state_d == StHalt);
        retired_d   = retired_q;
        if (retire && !(&retired_q)) retired_d = retired_q + RETIRE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            instr_q     <= '0;
            alu_op_q    <= ALU_NONE;
            reg_write_q <= 1'b0;
            imem_req_q  <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            imem_req_q  <= imem_req_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign alu_op    = alu_op_q;
    assign reg_write = reg_write_q;
    assign wb_addr   = instr_q[RD_MSB:RD_LSB];
    assign pc        = pc_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-level model fills scoreboard queues at each
// fetch; a monitor pops and compares whenever the DUT shows the matching event.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [1:0]  alu_op;
    logic        alu_zero = 1'b0;
    logic        reg_write;
    logic [5:0]  wb_addr;
    logic [15:0] pc;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    cpu_sequencer #(
        .PC_W     (16),
        .RETIRE_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .alu_op     (alu_op),
        .alu_zero   (alu_zero),
        .reg_write  (reg_write),
        .wb_addr    (wb_addr),
        .pc         (pc),
        .state      (state),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] ins; logic zero; int waits; } prog_t;
    typedef struct { logic [5:0] rd; logic [1:0] op; logic [15:0] ret; } wb_t;
    typedef struct { logic ill; logic [15:0] pc; logic [15:0] ret; } halt_t;

    prog_t       prog_q[$];
    logic [15:0] fetch_q[$];
    logic [31:0] instr_q[$];
    logic [1:0]  exec_q[$];
    wb_t         wb_q[$];
    halt_t       halt_q[$];

    int          checks = 0;
    int          failures = 0;
    bit          random_en = 1'b0;
    int          rand_left = 0;
    logic [15:0] mpc = 16'h0;
    logic [15:0] mret = 16'h0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void unexpected(string name, logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h with no expected entry at %0t", name, act, $time);
    endfunction

    // Reference: effect of one whole instruction on the architectural state
    function automatic void model_issue(logic [31:0] ins, logic zero);
        logic [5:0] op;
        logic [7:0] off;
        op  = ins[31:26];
        off = ins[25:18];
        instr_q.push_back(ins);
        mpc = mpc + 16'd1;
        case (op)
            6'd0: begin
                exec_q.push_back(2'b01);
                wb_q.push_back(wb_t'{ins[17:12], 2'b01, mret});
            end
            6'd1: begin
                exec_q.push_back(2'b10);
                wb_q.push_back(wb_t'{ins[17:12], 2'b10, mret});
            end
            6'd2: begin
                exec_q.push_back(2'b00);
                mpc = ins[15:0];
            end
            6'd3: begin
                exec_q.push_back(2'b10);
                if (zero) mpc = mpc + {{8{off[7]}}, off};
            end
            6'd63:   halt_q.push_back(halt_t'{1'b0, mpc, mret});
            default: halt_q.push_back(halt_t'{1'b1, mpc, mret});
        endcase
        if (op <= 6'd3) begin
            if (mret != 16'hFFFF) mret = mret + 16'd1;
            fetch_q.push_back(mpc);
        end
    endfunction

    function automatic logic [31:0] next_random();
        int unsigned r;
        logic [5:0]  op;
        logic [25:0] low;
        r   = $urandom_range(0, 99);
        low = 26'($urandom);
        if (rand_left > 0) begin
            rand_left--;
            if (r < 30) op = 6'd0;
            else if (r < 50) op = 6'd1;
            else if (r < 62) op = 6'd2;
            else op = 6'd3;
            if (op == 6'd2 && $urandom_range(0, 3) == 0) low[15:0] = 16'hFFFF;
        end else begin
            op = (r < 50) ? 6'd63 : 6'($urandom_range(4, 62));
        end
        return {op, low};
    endfunction

    // Instruction memory: serves program entries (or random ones) with wait states
    initial begin : driver
        prog_t p;
        bit    have;
        int    cnt;
        have = 1'b0;
        cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                fetch_q.delete();
                instr_q.delete();
                exec_q.delete();
                wb_q.delete();
                halt_q.delete();
                fetch_q.push_back(16'h0);
                mpc        = 16'h0;
                mret       = 16'h0;
                have       = 1'b0;
                imem_ready = 1'b0;
            end else if (imem_req) begin
                if (!have) begin
                    if (prog_q.size() > 0) begin
                        p    = prog_q.pop_front();
                        have = 1'b1;
                    end else if (random_en) begin
                        p.ins   = next_random();
                        p.zero  = 1'($urandom_range(0, 1));
                        p.waits = $urandom_range(0, 3);
                        have    = 1'b1;
                    end
                    cnt = have ? p.waits : 0;
                end
                if (!have || cnt > 0) begin
                    imem_ready = 1'b0;
                    imem_rdata = $urandom;
                    if (cnt > 0) cnt--;
                end else begin
                    imem_ready = 1'b1;
                    imem_rdata = p.ins;
                    alu_zero   = p.zero;
                    model_issue(p.ins, p.zero);
                    have = 1'b0;
                end
            end else begin
                imem_ready = random_en ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_rdata = $urandom;
            end
        end
    end

    initial begin : monitor
        logic  prev_halted;
        wb_t   w;
        halt_t h;
        prev_halted = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_halted = 1'b0;
            end else begin
                if (imem_req && imem_ready) begin
                    if (fetch_q.size() == 0) unexpected("fetch_addr", imem_addr);
                    else check("fetch_addr", imem_addr, fetch_q.pop_front());
                end
                if (state == 3'd2) begin
                    if (instr_q.size() == 0) unexpected("decode_instr", instr);
                    else check("decode_instr", instr, instr_q.pop_front());
                end
                if (state == 3'd3) begin
                    if (exec_q.size() == 0) unexpected("exec_alu_op", alu_op);
                    else check("exec_alu_op", alu_op, exec_q.pop_front());
                end
                if (reg_write) begin
                    if (wb_q.size() == 0) begin
                        unexpected("wb_addr", wb_addr);
                    end else begin
                        w = wb_q.pop_front();
                        check("wb_addr", wb_addr, w.rd);
                        check("wb_alu_op", alu_op, w.op);
                        check("wb_retired", retired, w.ret);
                    end
                end
                if (halted && !prev_halted) begin
                    if (halt_q.size() == 0) begin
                        unexpected("halt_event", pc);
                    end else begin
                        h = halt_q.pop_front();
                        check("halt_illegal", illegal, h.ill);
                        check("halt_pc", pc, h.pc);
                        check("halt_retired", retired, h.ret);
                    end
                end
                prev_halted = halted;
                check("reg_write_only_in_wb", reg_write && state != 3'd4, 1'b0);
                check("alu_op_idle", (state == 3'd3 || state == 3'd4) ? 2'b00 : alu_op, 2'b00);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        run       = 1'b0;
        random_en = 1'b0;
        prog_q.delete();
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic push(logic [31:0] ins, logic zero, int waits);
        prog_q.push_back(prog_t'{ins, zero, waits});
    endtask

    task automatic wait_halt(int budget, bit toggle);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            if (toggle) run = ($urandom_range(0, 7) != 0);
            n++;
        end
        checks++;
        if (!halted) begin
            failures++;
            $display("FAIL halt_timeout: halted=%0b expected 1 within %0d cycles", halted, budget);
        end
    endtask

    task automatic check_drained();
        @(negedge clk);
        #1;
        check("queues_drained", fetch_q.size() + instr_q.size() + exec_q.size()
              + wb_q.size() + halt_q.size(), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_state"}, state, 3'd0);
        check({tag, "_pc"}, pc, 16'h0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_alu_op"}, alu_op, 2'b00);
        check({tag, "_reg_write"}, reg_write, 1'b0);
        check({tag, "_imem_req"}, imem_req, 1'b0);
        check({tag, "_halted"}, halted, 1'b0);
        check({tag, "_illegal"}, illegal, 1'b0);
        check({tag, "_retired"}, retired, 16'h0);
    endtask

    initial begin : main
        int n;
        // ADD with zero-wait memory
        do_reset();
        push(32'h0000_3081, 1'b0, 0);
        push(32'hFC00_0000, 1'b0, 0);
        run = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            case (c)
                0: check_reset_outputs("reset");
                1: begin
                    check("add_c1_req", imem_req, 1'b1);
                    check("add_c1_addr", imem_addr, 16'h0);
                end
                2: begin
                    check("add_c2_instr", instr, 32'h0000_3081);
                    check("add_c2_pc", pc, 16'h1);
                end
                3: check("add_c3_alu_op", alu_op, 2'b01);
                4: begin
                    check("add_c4_reg_write", reg_write, 1'b1);
                    check("add_c4_wb_addr", wb_addr, 6'd3);
                    check("add_c4_alu_op", alu_op, 2'b01);
                end
                default: begin
                    check("add_c5_state", state, 3'd1);
                    check("add_c5_pc", pc, 16'h1);
                    check("add_c5_retired", retired, 16'h1);
                    check("add_c5_reg_write", reg_write, 1'b0);
                end
            endcase
        end
        wait_halt(100, 1'b0);
        check_drained();

        // Three wait states during fetch
        do_reset();
        push(32'h0000_3081, 1'b0, 3);
        push(32'hFC00_0000, 1'b0, 0);
        run = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                check("wait_req", imem_req, 1'b1);
                check("wait_addr", imem_addr, 16'h0);
                check("wait_instr", instr, 32'h0);
            end
            if (c == 7) check("wait_c7_reg_write", reg_write, 1'b1);
            if (c == 8) check("wait_c8_state", state, 3'd1);
        end
        wait_halt(100, 1'b0);
        check_drained();

        // JMP
        do_reset();
        push(32'h0800_1234, 1'b0, 0);
        push(32'h0000_3081, 1'b0, 0);
        push(32'hFC00_0000, 1'b0, 0);
        run = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) check("jmp_exec_alu_op", alu_op, 2'b00);
            if (c == 4) begin
                check("jmp_pc", pc, 16'h1234);
                check("jmp_next_addr", imem_addr, 16'h1234);
            end
        end
        wait_halt(100, 1'b0);
        check_drained();

        // BEQ at 0x0010 with offset -2, taken then not taken
        do_reset();
        push(32'h0800_0010, 1'b0, 0);
        push(32'h0FF8_0000, 1'b1, 0);
        push(32'h0800_0010, 1'b0, 0);
        push(32'h0FF8_0000, 1'b0, 0);
        push(32'hFC00_0000, 1'b0, 0);
        run = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 6) check("beq_exec_alu_op", alu_op, 2'b10);
            if (c == 7) check("beq_taken_pc", pc, 16'h000F);
        end
        wait_halt(200, 1'b0);
        check_drained();

        // PC wrap, illegal opcode, halt is sticky until reset
        do_reset();
        push(32'h0800_FFFF, 1'b0, 0);
        push(32'h0000_3081, 1'b0, 0);
        push(32'h5400_0000, 1'b0, 1);
        run = 1'b1;
        wait_halt(200, 1'b0);
        check_drained();
        for (int i = 0; i < 10; i++) begin
            tick();
            run = ~run;
        end
        check("halt_sticky_state", state, 3'd5);
        check("halt_sticky_halted", halted, 1'b1);
        check("halt_sticky_illegal", illegal, 1'b1);
        reset = 1'b1;
        tick();
        check_reset_outputs("halt_reset");

        // Reset asserted during the second WRITEBACK
        do_reset();
        push(32'h0000_3081, 1'b0, 0);
        push(32'h0000_5081, 1'b0, 0);
        push(32'h0000_3081, 1'b0, 0);
        run = 1'b1;
        n = 0;
        while (!(state == 3'd4 && retired == 16'h1) && n < 60) begin
            tick();
            n++;
        end
        check("wb_reset_reached", state, 3'd4);
        reset = 1'b1;
        tick();
        check("wb_reset_reg_write", reg_write, 1'b0);
        check("wb_reset_state", state, 3'd0);
        check("wb_reset_pc", pc, 16'h0);
        check("wb_reset_retired", retired, 16'h0);

        // Dropping run in EXECUTE completes the instruction, then idles
        do_reset();
        push(32'h0000_3081, 1'b0, 0);
        push(32'hFC00_0000, 1'b0, 0);
        run = 1'b1;
        n = 0;
        while (state != 3'd3 && n < 20) begin
            tick();
            n++;
        end
        check("drop_run_reached_exec", state, 3'd3);
        run = 1'b0;
        tick();
        check("drop_run_wb", reg_write, 1'b1);
        tick();
        check("drop_run_idle", state, 3'd0);
        check("drop_run_retired", retired, 16'h1);
        repeat (3) tick();
        check("drop_run_stays_idle", state, 3'd0);
        run = 1'b1;
        wait_halt(100, 1'b0);
        check_drained();

        // Randomized programs with random wait states and run toggling
        for (int k = 0; k < 8; k++) begin
            do_reset();
            rand_left = $urandom_range(10, 40);
            random_en = 1'b1;
            run       = 1'b1;
            wait_halt(3000, 1'b1);
            check_drained();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit Harvard core. It owns the PC and the instruction register, and fetches 32-bit instructions from instruction memory through a req/ready handshake. It presents the latched instruction to decode/register_file and steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. It drives alu_op, reg_write and the writeback address, resolves jumps and branches, and halts on HALT or on an illegal opcode.

Parameters:
PC_W, 16, PC / instruction-memory address width
RETIRE_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
run  input  1  start/continue; sampled in IDLE and at instruction end
imem_req  output  1  fetch request
imem_addr  output  PC_W  fetch address (current PC)
imem_ready  input  1  fetch data valid this cycle
imem_rdata  input  32  fetched instruction
instr  output  32  instruction register, fed to decode/register_file
alu_op  output  2  00 none, 01 add, 10 sub
alu_zero  input  1  ALU result == 0
reg_write  output  1  register file write enable
wb_addr  output  6  destination register, instr[17:12]
pc  output  PC_W  current PC
state  output  3  FSM state, for debug
halted  output  1  core stopped
illegal  output  1  halt cause was an undefined opcode
retired  output  RETIRE_W  count of completed instructions, saturating

Behaviour:
- Single clock (clk). Reset is synchronous and active-high on reset. Reset takes priority in every state, including mid-fetch: state=IDLE, pc=0, instr=0, all outputs 0, retired=0.
- Instruction fields:
  - opcode instr[31:26]
  - rs1 instr[5:0], rs2 instr[11:6], rd instr[17:12]
  - jump target instr[15:0]
  - branch offset instr[25:18], 8-bit signed
- Opcodes: 000000 ADD, 000001 SUB, 000010 JMP, 000011 BEQ, 111111 HALT. Every other opcode is illegal.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- IDLE: all controls 0. run=1 -> FETCH on the next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ready.
  - On imem_ready: instr<=imem_rdata, pc<=pc+1 (mod 2^PC_W, so 0xFFFF wraps to 0x0000), -> DECODE.
  - No timeout; the FSM waits indefinitely.
- DECODE (1 cycle): register file reads settle from instr.
  - HALT opcode -> HALT with illegal=0.
  - Undefined opcode -> HALT with illegal=1.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle):
  - ADD: alu_op=01, -> WRITEBACK.
  - SUB: alu_op=10, -> WRITEBACK.
  - JMP: alu_op=00, pc<=instr[15:0], retire.
  - BEQ: alu_op=10. If alu_zero, pc<=pc+sext(offset), where pc is already branch_addr+1 and the sum is mod 2^PC_W. Retire.
- WRITEBACK (1 cycle): alu_op held at the EXECUTE value, reg_write=1, wb_addr=instr[17:12]. Retire.
- Retire:
  - retired increments by 1, saturating at all-ones.
  - Next state is FETCH if run=1, otherwise IDLE.
- HALT: halted=1; illegal holds its cause; all other controls 0. The FSM stays in HALT until reset, and run is ignored.
- Timing:
  - reg_write is high for exactly one cycle per ADD/SUB and never for any other opcode.
  - alu_op is 00 outside EXECUTE and WRITEBACK.
  - With zero-wait memory: ADD/SUB take 4 cycles, JMP/BEQ take 3 cycles. Each cycle imem_ready is low adds one cycle.
- imem_ready is ignored outside FETCH.
- Dropping run mid-instruction does not abort it; the stop takes effect at retire.
- All outputs are registered, except imem_addr (=pc) and wb_addr (=instr[17:12]), which are direct wires from registers.

Decomposition:
- Shared include cpu_defs.vh holds:
  - opcode constants (OP_ADD, OP_SUB, OP_JMP, OP_BEQ, OP_HALT)
  - ALU_NONE/ALU_ADD/ALU_SUB encodings
  - FSM state constants
  - field bit positions
- Natural sub-module: instr_classify, purely combinational. Input opcode; outputs is_alu, is_jmp, is_beq, is_halt, is_illegal, alu_sel.
- PC, instruction register, FSM and counter stay in cpu_sequencer.

Test Plan:
- Reset, run=1, memory word 0 = ADD (0x0000_3081: rd=3, rs2=2, rs1=1), zero-wait memory -> imem_addr=0 in cycle 1. alu_op=01 in cycles 3-4, reg_write=1 only in cycle 4 with wb_addr=3. pc=1, retired=1. FETCH again at cycle 5.
- imem_ready held low for 3 cycles in FETCH -> imem_req and imem_addr stable throughout. instr unchanged until ready. Total ADD latency 7 cycles.
- JMP 0x0800_1234 at pc=0 -> pc=0x1234 after EXECUTE, no reg_write, next imem_addr=0x1234.
- BEQ at pc=0x0010 with offset 0xFE (-2):
  - alu_zero=1 -> pc=0x000F
  - alu_zero=0 -> pc=0x0011
  - alu_op=10 in EXECUTE only.
- pc=0xFFFF fetch -> pc wraps to 0x0000. Opcode 0x15 -> HALT with illegal=1, halted=1; run toggling leaves it there. Reset -> IDLE, all outputs 0.
- Assert reset during WRITEBACK -> reg_write=0 next cycle, state=IDLE, pc=0, retired=0. Drop run during EXECUTE -> the instruction completes, then IDLE.
